// File: rtl/pkg_tpu.sv
// Shared TPU backend types: datapath word, execute-stage token and shift opcodes.
package pkg_tpu;

  localparam int WIDTH_DATA  = 32;
  localparam int WIDTH_SHAMT = $clog2(WIDTH_DATA);

  typedef logic [WIDTH_DATA-1:0] data_t;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SLA = 2'b01;
  localparam logic [1:0] SHIFT_SRL = 2'b10;
  localparam logic [1:0] SHIFT_SRA = 2'b11;

  typedef struct packed {
    logic [3:0] OpCode;
    logic [1:0] Mode;
  } op_t;

  typedef struct packed {
    op_t        op;
    logic [7:0] Dst;
  } pipe_exe_tmp_t;

endpackage

// File: rtl/Shift_Unit.sv
// Combinational barrel shifter; output is forced to zero when not enabled.
module Shift_Unit
  import pkg_tpu::*;
(
  input  logic                   en,
  input  logic [1:0]             opcode,
  input  data_t                  data,
  input  logic [WIDTH_SHAMT-1:0] shamt,
  output data_t                  result
);

  logic signed [WIDTH_DATA-1:0] data_s;

  assign data_s = signed'(data);

  always_comb begin
    result = '0;
    if (en) begin
      case (opcode)
        SHIFT_SLL, SHIFT_SLA: result = data << shamt;
        SHIFT_SRL:            result = data >> shamt;
        SHIFT_SRA:            result = data_t'(data_s >>> shamt);
      endcase
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter feeding a shared two-stage shift pipeline (operand reg,
// result reg) with back-pressure from downstream and requester-ID tagging.
module shift_arbiter
  import pkg_tpu::*;
#(
  parameter int  NUM_REQ = 4,
  parameter type TYPE    = pipe_exe_tmp_t
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         I_Req,
  input  data_t                      I_Data1 [NUM_REQ],
  input  data_t                      I_Data2 [NUM_REQ],
  input  TYPE                        I_Token [NUM_REQ],
  output logic [NUM_REQ-1:0]         O_Grant,
  input  logic                       I_Stall,
  output logic                       O_Valid,
  output data_t                      O_Data,
  output TYPE                        O_Token,
  output logic [$clog2(NUM_REQ)-1:0] O_ReqID,
  output logic                       O_Busy
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0]         ptr;
  logic [IDW-1:0]         ptr_nxt;
  logic [IDW-1:0]         gnt_id;
  logic [IDW-1:0]         cand;
  logic [NUM_REQ-1:0]     grant;
  logic                   take;
  logic                   found;
  logic                   adv1;
  logic                   adv2;

  logic                   vld_p1;
  data_t                  data1_p1;
  logic [WIDTH_SHAMT-1:0] amt_p1;
  TYPE                    tok_p1;
  logic [IDW-1:0]         id_p1;

  logic                   vld_p2;
  data_t                  res_p2;
  TYPE                    tok_p2;
  logic [IDW-1:0]         id_p2;

  data_t                  shift_res;
  logic                   unused_amt;

  assign adv2 = !vld_p2 || !I_Stall;
  assign adv1 = !vld_p1 || adv2;

  // Stage 0: priority search from ptr, wrapping modulo NUM_REQ
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    cand    = '0;
    if (reset && adv1) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = IDW'((int'(ptr) + k) % NUM_REQ);
        if (!found && I_Req[cand]) begin
          found        = 1'b1;
          grant[cand]  = 1'b1;
          gnt_id       = cand;
          ptr_nxt      = IDW'((int'(cand) + 1) % NUM_REQ);
        end
      end
    end
  end

  assign take    = |grant;
  assign O_Grant = grant;

  // Only the low shift-amount bits travel down the pipe.
  always_comb begin
    unused_amt = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      unused_amt = unused_amt ^ (^I_Data2[i][WIDTH_DATA-1:WIDTH_SHAMT]);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      ptr    <= '0;
    end else begin
      if (adv1) vld_p1 <= take;
      if (adv2) vld_p2 <= vld_p1;
      if (take) ptr    <= ptr_nxt;
    end
  end

  // Stage 1: operand register
  always_ff @(posedge clock) begin
    if (take) begin
      data1_p1 <= I_Data1[gnt_id];
      amt_p1   <= I_Data2[gnt_id][WIDTH_SHAMT-1:0];
      tok_p1   <= I_Token[gnt_id];
      id_p1    <= gnt_id;
    end
  end

  Shift_Unit u_shift (
    .en     (vld_p1),
    .opcode (tok_p1.op.OpCode[1:0]),
    .data   (data1_p1),
    .shamt  (amt_p1),
    .result (shift_res)
  );

  // Stage 2: result register, held while downstream stalls
  always_ff @(posedge clock) begin
    if (adv2 && vld_p1) begin
      res_p2 <= shift_res;
      tok_p2 <= tok_p1;
      id_p2  <= id_p1;
    end
  end

  assign O_Valid = vld_p2;
  assign O_Data  = vld_p2 ? res_p2 : '0;
  assign O_Token = vld_p2 ? tok_p2 : '0;
  assign O_ReqID = vld_p2 ? id_p2  : '0;
  assign O_Busy  = vld_p1 || vld_p2;

endmodule
